usr_seq_ctrl: RTL

//  Sequencer for the universal shift register (USR: s/din/sin in, q out).

---
 rtl/usr_seq_ctrl_if.sv | 29 ++
 rtl/usr_seq_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/usr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : usr_seq_ctrl_if
// Brief    : Command/response handshake bundle between a master and usr_seq_ctrl.
// Revision : 1.0
// ============================================================================
interface usr_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/usr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usr_seq_ctrl
// Brief    : Drives a universal shift register through one load and WIDTH
//            shifts per command (TX serialise / RX deserialise).
// Revision : 1.0
// ============================================================================
module usr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    usr_seq_ctrl_if.slave         bus,
    input  wire logic             ser_in,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic [1:0]            s,
    output logic [WIDTH-1:0]      din,
    output logic                  sin,
    input  wire logic [WIDTH-1:0] q,
    output logic                  busy
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]       C_S_HOLD   = 2'b00;
    localparam logic [1:0]       C_S_RIGHT  = 2'b01;
    localparam logic [1:0]       C_S_LEFT   = 2'b10;
    localparam logic [1:0]       C_S_LOAD   = 2'b11;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic               cmd_ready;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            dir_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dir_d     = dir_q;
        data_d    = data_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        s         = C_S_HOLD;
        din       = '0;
        sin       = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                // Held low during reset so the master never sees a phantom accept.
                cmd_ready = ~rst;
                if (bus.cmd_valid && cmd_ready) begin
                    op_d    = bus.cmd_op;
                    dir_d   = bus.cmd_dir;
                    data_d  = bus.cmd_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s       = C_S_LOAD;
                din     = op_q ? '0 : data_q;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                s         = dir_q ? C_S_LEFT : C_S_RIGHT;
                ser_valid = 1'b1;
                // TX zero-fills so the register ends empty; RX feeds the line in.
                sin       = op_q ? ser_in : 1'b0;
                ser_out   = op_q ? 1'b0 : (dir_q ? q[WIDTH-1] : q[0]);
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = q;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;

endmodule
`default_nettype wire
